// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues one outstanding imem read at a time and buffers each returned
// word in the IF/ID register, with a one-entry skid and redirect/flush handling.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        decode_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        discard_q, discard_d;
    logic        req_valid_q, req_valid_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_pc4_q, out_pc4_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        out_free;

    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        discard_d    = discard_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_pc_d     = out_pc_q;
        out_pc4_d    = out_pc4_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_pc_d    = skid_pc_q;
        out_free     = !out_valid_q || !decode_stall;

        // Consumed with nothing to replace it: drop to a nop, keep the pc fields.
        if (out_valid_q && !decode_stall) begin
            out_valid_d = 1'b0;
            out_data_d  = 32'h0;
        end

        if (redirect_valid) begin
            out_valid_d  = 1'b0;
            out_data_d   = 32'h0;
            skid_valid_d = 1'b0;
            fetch_pc_d   = {redirect_pc[31:2], 2'b00};
            state_d      = StReq;
            unique case (state_q)
                StWait: begin
                    discard_d = !imem_resp_valid;
                    if (!imem_resp_valid) state_d = StWait;
                end
                StReq: begin
                    // The stale request is already accepted; its response must be dropped.
                    if (imem_req_ready) begin
                        discard_d = 1'b1;
                        state_d   = StWait;
                    end
                end
                StIdle, StHold: ;
            endcase
        end else begin
            unique case (state_q)
                StIdle: state_d = StReq;
                StReq: begin
                    if (imem_req_ready) begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = StWait;
                    end
                end
                StWait: begin
                    if (imem_resp_valid) begin
                        state_d = StReq;
                        if (discard_q) begin
                            discard_d = 1'b0;
                        end else if (out_free) begin
                            out_valid_d = 1'b1;
                            out_data_d  = imem_resp_data;
                            out_pc_d    = req_pc_q;
                            out_pc4_d   = req_pc_q + 32'd4;
                        end else begin
                            skid_valid_d = 1'b1;
                            skid_data_d  = imem_resp_data;
                            skid_pc_d    = req_pc_q;
                            state_d      = StHold;
                        end
                    end
                end
                StHold: begin
                    if (!decode_stall) begin
                        out_valid_d  = 1'b1;
                        out_data_d   = skid_data_q;
                        out_pc_d     = skid_pc_q;
                        out_pc4_d    = skid_pc_q + 32'd4;
                        skid_valid_d = 1'b0;
                        state_d      = StReq;
                    end
                end
            endcase
        end

        req_valid_d = (state_d == StReq);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            fetch_pc_q   <= RESET_PC;
            req_pc_q     <= RESET_PC;
            discard_q    <= 1'b0;
            req_valid_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 32'h0;
            out_pc_q     <= 32'h0;
            out_pc4_q    <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= 32'h0;
            skid_pc_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            discard_q    <= discard_d;
            req_valid_q  <= req_valid_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_pc_q     <= out_pc_d;
            out_pc4_q    <= out_pc4_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = fetch_pc_q;
    assign instr_valid    = out_valid_q;
    assign instruction    = out_data_q;
    assign instr_pc       = out_pc_q;
    assign instr_pc_plus4 = out_pc4_q;

endmodule
